// File: rtl/sfu_acc_ctrl.sv
// Sequencer for the SFU accumulate pass: walks psum SRAM reads per output pixel,
// steers the SFU accumulate/bypass controls and issues the output SRAM writes.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; config latched on the start cycle
// S_READ  | one psum read per cycle (WS: K reads per pixel, OS: 1)
// S_GAP   | WS only: one idle read slot so acc drops between pixels
// S_FLUSH | reads finished, waiting for the last output write to issue
// S_DONE  | one-cycle completion pulse, back to S_IDLE
module sfu_acc_ctrl #(
   parameter int addr_w = 11,
   parameter int kij_w  = 4,
   parameter int pix_w  = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode_ws,
   input  logic              bypass_cfg,
   input  logic [kij_w-1:0]  num_kij,
   input  logic [pix_w-1:0]  num_pix,
   output logic              psum_rd_en,
   output logic [addr_w-1:0] psum_rd_addr,
   output logic              sfu_acc_o,
   output logic              sfu_bypass_o,
   output logic              out_wr_en,
   output logic [addr_w-1:0] out_wr_addr,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_GAP, S_FLUSH, S_DONE} state_t;

   state_t             state, state_nxt;
   logic               ws_q, ws_nxt;
   logic               byp_q, byp_nxt;
   logic [kij_w-1:0]   kk_q, kk_nxt;
   logic [pix_w-1:0]   last_q, last_nxt;
   logic [addr_w-1:0]  step_q, step_nxt;
   logic [kij_w-1:0]   kij_left, kij_nxt;
   logic [pix_w-1:0]   pix_cnt, pix_nxt;
   logic [addr_w-1:0]  addr_nxt;
   logic               flush_cnt, flush_nxt;
   logic               d1;
   logic [addr_w-1:0]  d1_pix;
   logic               trig;
   logic               wr_en_nxt;
   logic [addr_w-1:0]  wr_addr_nxt;

   // psum_rd_addr doubles as the running address; it is forced to zero
   // outside READ, and every entry into READ reloads it from the pixel index.
   always_comb begin
      state_nxt = state;
      ws_nxt    = ws_q;
      byp_nxt   = byp_q;
      kk_nxt    = kk_q;
      last_nxt  = last_q;
      step_nxt  = step_q;
      kij_nxt   = kij_left;
      pix_nxt   = pix_cnt;
      addr_nxt  = '0;
      flush_nxt = flush_cnt;
      case (state)
         S_IDLE: begin
            if (start) begin
               ws_nxt   = mode_ws;
               byp_nxt  = bypass_cfg;
               kk_nxt   = (mode_ws && num_kij != '0) ? num_kij - kij_w'(1) : '0;
               last_nxt = num_pix - pix_w'(1);
               step_nxt = addr_w'(num_pix);
               pix_nxt  = '0;
               kij_nxt  = kk_nxt;
               state_nxt = (num_pix == '0) ? S_DONE : S_READ;
            end
         end
         S_READ: begin
            if (kij_left != '0) begin
               kij_nxt  = kij_left - kij_w'(1);
               addr_nxt = psum_rd_addr + step_q;
            end else if (ws_q) begin
               state_nxt = S_GAP;
            end else if (pix_cnt == last_q) begin
               state_nxt = S_FLUSH;
               flush_nxt = 1'b0;
            end else begin
               pix_nxt  = pix_cnt + pix_w'(1);
               addr_nxt = addr_w'(pix_nxt);
            end
         end
         S_GAP: begin
            if (pix_cnt == last_q) begin
               state_nxt = S_FLUSH;
               flush_nxt = 1'b1;
            end else begin
               pix_nxt   = pix_cnt + pix_w'(1);
               addr_nxt  = addr_w'(pix_nxt);
               kij_nxt   = kk_q;
               state_nxt = S_READ;
            end
         end
         S_FLUSH: begin
            if (!flush_cnt) state_nxt = S_DONE;
            else            flush_nxt = 1'b0;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // WS writes land two cycles after the GAP (SFU accumulate latency); OS writes
   // follow the read by one cycle.
   always_comb begin
      trig        = (state == S_GAP) || (state == S_READ && !ws_q);
      wr_en_nxt   = ws_q ? d1 : trig;
      wr_addr_nxt = '0;
      if (wr_en_nxt) wr_addr_nxt = ws_q ? d1_pix : addr_w'(pix_cnt);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         ws_q         <= 1'b0;
         byp_q        <= 1'b0;
         kk_q         <= '0;
         last_q       <= '0;
         step_q       <= '0;
         kij_left     <= '0;
         pix_cnt      <= '0;
         flush_cnt    <= 1'b0;
         d1           <= 1'b0;
         d1_pix       <= '0;
         psum_rd_en   <= 1'b0;
         psum_rd_addr <= '0;
         sfu_acc_o    <= 1'b0;
         sfu_bypass_o <= 1'b0;
         out_wr_en    <= 1'b0;
         out_wr_addr  <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state        <= state_nxt;
         ws_q         <= ws_nxt;
         byp_q        <= byp_nxt;
         kk_q         <= kk_nxt;
         last_q       <= last_nxt;
         step_q       <= step_nxt;
         kij_left     <= kij_nxt;
         pix_cnt      <= pix_nxt;
         flush_cnt    <= flush_nxt;
         d1           <= (state == S_GAP);
         d1_pix       <= addr_w'(pix_cnt);
         psum_rd_en   <= (state_nxt == S_READ);
         psum_rd_addr <= addr_nxt;
         sfu_acc_o    <= psum_rd_en & ws_q;
         sfu_bypass_o <= (state_nxt != S_IDLE) & byp_nxt;
         out_wr_en    <= wr_en_nxt;
         out_wr_addr  <= wr_addr_nxt;
         busy         <= (state_nxt != S_IDLE);
         done         <= (state_nxt == S_DONE);
      end
   end

endmodule

// File: tb/tb_sfu_acc_ctrl.sv
// Bench for sfu_acc_ctrl: per-cycle output trace compared against a schedule
// computed arithmetically from the configuration.
module tb_sfu_acc_ctrl;
   localparam int AW = 11;
   localparam int KW = 4;
   localparam int PW = 7;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          mode_ws = 1'b0;
   logic          bypass_cfg = 1'b0;
   logic [KW-1:0] num_kij = '0;
   logic [PW-1:0] num_pix = '0;
   logic          psum_rd_en;
   logic [AW-1:0] psum_rd_addr;
   logic          sfu_acc_o;
   logic          sfu_bypass_o;
   logic          out_wr_en;
   logic [AW-1:0] out_wr_addr;
   logic          busy;
   logic          done;

   int checks = 0;
   int errors = 0;

   // trace word: busy[27] done[26] rd_en[25] rd_addr[24:14] acc[13] byp[12] wr_en[11] wr_addr[10:0]
   logic [27:0] exp_tr [0:4095];
   int          exp_len;

   sfu_acc_ctrl #(.addr_w(AW), .kij_w(KW), .pix_w(PW)) dut (
      .clk(clk), .reset(rst_n), .start(start), .mode_ws(mode_ws),
      .bypass_cfg(bypass_cfg), .num_kij(num_kij), .num_pix(num_pix),
      .psum_rd_en(psum_rd_en), .psum_rd_addr(psum_rd_addr),
      .sfu_acc_o(sfu_acc_o), .sfu_bypass_o(sfu_bypass_o),
      .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [27:0] obs();
      return {busy, done, psum_rd_en, psum_rd_addr, sfu_acc_o, sfu_bypass_o,
              out_wr_en, out_wr_addr};
   endfunction

   // Cycle 0 is the cycle in which start is high.
   task automatic build_model(input bit ws, input bit byp, input int kij, input int pix);
      int k;
      int d;
      int rc;
      int wc;
      k = (kij == 0) ? 1 : kij;
      for (int i = 0; i < 4096; i++) exp_tr[i] = '0;
      if (pix == 0)  d = 1;
      else if (ws)   d = (pix - 1) * (k + 1) + k + 4;
      else           d = pix + 2;
      for (int c = 1; c <= d; c++) begin
         exp_tr[c][27] = 1'b1;
         exp_tr[c][12] = byp;
      end
      exp_tr[d][26] = 1'b1;
      for (int p = 0; p < pix; p++) begin
         if (ws) begin
            for (int j = 0; j < k; j++) begin
               rc = 1 + p * (k + 1) + j;
               exp_tr[rc][25]    = 1'b1;
               exp_tr[rc][24:14] = AW'((j * pix + p) % (1 << AW));
               exp_tr[rc + 1][13] = 1'b1;
            end
            wc = p * (k + 1) + k + 3;
         end else begin
            rc = 1 + p;
            exp_tr[rc][25]    = 1'b1;
            exp_tr[rc][24:14] = AW'(p);
            wc = 2 + p;
         end
         exp_tr[wc][11]   = 1'b1;
         exp_tr[wc][10:0] = AW'(p);
      end
      exp_len = d + 2;
   endtask

   task automatic check(input string tag, input int c, input logic [27:0] e);
      checks++;
      assert (obs() === e) else begin
         errors++;
         $error("FAIL %s cycle %0d observed %h expected %h", tag, c, obs(), e);
      end
   endtask

   // mid: cycle of a stray start pulse (0 = none); rst_at: cycle to assert reset (0 = none)
   task automatic run_check(input string tag, input bit ws, input bit byp, input int kij,
                            input int pix, input int mid, input int rst_at);
      build_model(ws, byp, kij, pix);
      @(negedge clk);
      mode_ws    = ws;
      bypass_cfg = byp;
      num_kij    = KW'(kij);
      num_pix    = PW'(pix);
      start      = 1'b1;
      for (int c = 1; c <= exp_len; c++) begin
         @(negedge clk);
         start      = (c == mid);
         mode_ws    = 1'($urandom_range(0, 1));
         bypass_cfg = 1'($urandom_range(0, 1));
         num_kij    = KW'($urandom);
         num_pix    = PW'($urandom);
         check(tag, c, exp_tr[c]);
         if (c == rst_at) begin
            start = 1'b0;
            rst_n = 1'b0;
            #1;
            check({tag, "_rst_now"}, c, '0);
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               check({tag, "_rst_hold"}, c + 1 + i, '0);
            end
            rst_n = 1'b1;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               check({tag, "_post_rst"}, i, '0);
            end
            return;
         end
      end
      start = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset", i, '0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("idle", 0, '0);

      run_check("ws_k9_p16",   1'b1, 1'b0, 9, 16, 0, 0);
      run_check("os_p4",       1'b0, 1'b0, 0, 4, 0, 0);
      run_check("ws_k0_p5",    1'b1, 1'b0, 0, 5, 0, 0);
      run_check("ws_k1_p5",    1'b1, 1'b0, 1, 5, 0, 0);
      run_check("ws_p0",       1'b1, 1'b1, 5, 0, 0, 0);
      run_check("os_p0",       1'b0, 1'b0, 3, 0, 0, 0);
      run_check("ws_midstart", 1'b1, 1'b0, 3, 6, 7, 0);
      run_check("os_midstart", 1'b0, 1'b1, 2, 5, 3, 0);
      run_check("ws_bypass",   1'b1, 1'b1, 2, 4, 0, 0);
      run_check("ws_reset",    1'b1, 1'b0, 4, 8, 0, 17);
      run_check("ws_fresh",    1'b1, 1'b0, 4, 8, 0, 0);
      run_check("ws_k15_p127", 1'b1, 1'b0, 15, 127, 0, 0);
      run_check("os_p127",     1'b0, 1'b1, 15, 127, 0, 0);

      for (int r = 0; r < 8; r++) begin
         run_check("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 20)), 0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sfu_acc_ctrl.md
SFU_ACC_CTRL -- requirements
Module: sfu_acc_ctrl

Interface
REQ-001 SHALL have parameter addr_w, default 11, psum/output SRAM address width.
REQ-002 SHALL have parameter kij_w, default 4, width of the kernel-pass count.
REQ-003 SHALL have parameter pix_w, default 7, width of the output-pixel count.
REQ-004 SHALL have ports, in order:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle launch pulse.
- mode_ws  in  1  1 = weight-stationary accumulate, 0 = output-stationary ReLU-only.
- bypass_cfg  in  1  psum bypass request.
- num_kij  in  kij_w  kernel passes per output pixel.
- num_pix  in  pix_w  output pixels.
- psum_rd_en  out  1  psum SRAM read strobe; data returns on the SFU input 1 cycle later.
- psum_rd_addr  out  addr_w  psum SRAM read address.
- sfu_acc_o  out  1  drives SFU acc_i.
- sfu_bypass_o  out  1  drives SFU psum_bypass_i.
- out_wr_en  out  1  output SRAM write strobe; SFU output is valid this cycle.
- out_wr_addr  out  addr_w  output SRAM write address.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.

Function
REQ-005 SHALL sample mode_ws, bypass_cfg, num_kij and num_pix on the cycle start=1 in IDLE, and hold them for the whole sequence.
REQ-006 SHALL ignore start while busy=1.
REQ-007 SHALL treat num_kij=0 as 1.
REQ-008 SHALL, for num_pix=0, pulse done 1 cycle after start, with no reads or writes.
REQ-009 SHALL implement states IDLE, READ, GAP, FLUSH, DONE; busy=1 in every state except IDLE.
REQ-010 SHALL, in WS READ, issue K=num_kij consecutive reads for pixel p at addresses kij*num_pix+p, kij=0..K-1.
REQ-011 SHALL form each address with an incremental base adder, no multiplier; addresses wrap modulo 2^addr_w.
REQ-012 SHALL, in WS, follow each pixel's K reads with exactly one GAP cycle (psum_rd_en=0), then start pixel p+1; pixel period = K+1 cycles.
REQ-013 SHALL drive sfu_acc_o equal to psum_rd_en delayed by one register stage; this leaves it low for exactly one cycle between pixels.
REQ-014 SHALL, in WS, assert out_wr_en with out_wr_addr=p exactly 2 cycles after pixel p's GAP cycle.
REQ-015 SHALL allow that write to coincide with pixel p+1's first accumulate cycle.
REQ-016 SHALL, in OS mode, issue one read per cycle at address p (p=0..num_pix-1) with no GAP, hold sfu_acc_o=0, and assert out_wr_en with out_wr_addr=p one cycle after each read.
REQ-017 SHALL, after the last pixel's reads (WS: its GAP), enter FLUSH until the last write has issued, then DONE.
REQ-018 SHALL pulse done=1 in the DONE cycle, one cycle after the final out_wr_en, then return to IDLE.
REQ-019 SHALL accept start in the cycle after DONE.
REQ-020 SHALL drive sfu_bypass_o from the latched bypass_cfg while busy, and 0 in IDLE.
REQ-021 SHALL keep the read/write schedule unchanged when bypass is set.
REQ-022 SHALL register all outputs; no combinational path from any input to any output.

Reset
REQ-023 SHALL, on reset=0 at any time including mid-sequence, go to IDLE and zero every output, counter and latched config.
REQ-024 SHALL drop all pending writes and emit no done when reset is applied mid-sequence.
REQ-025 SHALL issue the first read no earlier than the cycle after start following reset release.

Verification
REQ-026 WS, num_kij=9, num_pix=16, start at cycle 0:
- pixel 0 reads at addresses 0,16,...,128.
- sfu_acc_o high 9 cycles, low 1 cycle.
- out_wr_en at addr 0 in cycle 12; 16 writes total, spaced 10 cycles apart.
- done 1 cycle after the write to addr 15.
REQ-027 OS, num_pix=4:
- reads at addresses 0..3 in cycles 1..4; sfu_acc_o stays 0.
- writes at addresses 0..3 in cycles 2..5; done in cycle 6.
REQ-028 Edge configs:
- num_kij=0 behaves identically to num_kij=1.
- num_pix=0 gives done one cycle after start, with no read or write strobes.
REQ-029 Second start pulse mid-sequence is ignored; the read/write address trace is identical to a single-start run.
REQ-030 Reset asserted during pixel 3 of a WS run:
- all outputs 0 the same cycle; no further write, no done.
- a fresh start runs correctly from pixel 0.
REQ-031 num_kij=15, num_pix=127, addr_w=11: the highest address, 14*127+126=1904, is issued correctly with no truncation error.
